// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array writeback path.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } wb_state_t;

    localparam int SHIFT_MAX = 20;

    // Accumulator width: full product plus 5 bits of growth headroom.
    function automatic int outcome_width(input int data_width);
        return 2 * data_width + 5;
    endfunction

endpackage

// File: rtl/systolic_requant_lane.sv
// One output lane: round-half-up, arithmetic right shift, saturate, optional ReLU.
// Optional feature: define SYSTOLIC_WB_RELU_EN to clamp negative results to zero.
module systolic_requant_lane
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int OUTCOME_WIDTH = 21
) (
    input  logic signed [OUTCOME_WIDTH-1:0] outcome,
    input  logic        [4:0]               shift,
    output logic        [DATA_WIDTH-1:0]    result
);

    localparam logic signed [OUTCOME_WIDTH:0] SAT_MAX =
        {{(OUTCOME_WIDTH+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [OUTCOME_WIDTH:0] SAT_MIN =
        {{(OUTCOME_WIDTH+2-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [OUTCOME_WIDTH:0] ext;
    logic signed [OUTCOME_WIDTH:0] rnd;
    logic signed [OUTCOME_WIDTH:0] sum;
    logic signed [OUTCOME_WIDTH:0] shr;
    logic        [DATA_WIDTH-1:0]  sat;

    // One extra bit keeps the rounding add from wrapping at the positive extreme.
    always_comb begin
        ext = {outcome[OUTCOME_WIDTH-1], outcome};
        rnd = '0;
        if (shift != 5'd0)
            rnd = (OUTCOME_WIDTH+1)'(1) << (shift - 5'd1);
        sum = ext + rnd;
        shr = sum >>> shift;
        if (shr > SAT_MAX)
            sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (shr < SAT_MIN)
            sat = SAT_MIN[DATA_WIDTH-1:0];
        else
            sat = shr[DATA_WIDTH-1:0];
    end

`ifdef SYSTOLIC_WB_RELU_EN
    assign result = sat[DATA_WIDTH-1] ? '0 : sat;
`else
    assign result = sat;
`endif

endmodule

// File: rtl/systolic_writeback.sv
// Drains the systolic array one vector per cycle, requantizes and writes to output SRAM.
// Optional feature: SYSTOLIC_WB_RELU_EN enables ReLU in every requant lane.
//
// state    | meaning
// ST_IDLE  | waiting for drain_start
// ST_DRAIN | issuing matrix_index 0..ARRAY_SIZE-1, one per cycle
// ST_FLUSH | last vectors moving through the 2-stage pipeline
module systolic_writeback
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 10,
    localparam int OUTCOME_WIDTH = outcome_width(DATA_WIDTH)
) (
    input  logic                                       clk,
    input  logic                                       srstn,
    input  logic                                       drain_start,
    input  logic        [4:0]                          shift_amt,
    input  logic        [ADDR_WIDTH-1:0]               base_addr,
    output logic        [5:0]                          matrix_index,
    input  logic signed [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
    output logic                                       sram_wen,
    output logic        [ADDR_WIDTH-1:0]               sram_waddr,
    output logic        [ARRAY_SIZE*DATA_WIDTH-1:0]    sram_wdata,
    output logic                                       busy,
    output logic                                       done
);

    wb_state_t                                  state;
    logic        [4:0]                          shift_q;
    logic        [ADDR_WIDTH-1:0]               base_q;
    logic                                       s1_valid;
    logic        [5:0]                          s1_idx;
    logic signed [ARRAY_SIZE*OUTCOME_WIDTH-1:0] s1_data;
    logic        [ARRAY_SIZE*DATA_WIDTH-1:0]    lane_res;

    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
        systolic_requant_lane #(
            .DATA_WIDTH   (DATA_WIDTH),
            .OUTCOME_WIDTH(OUTCOME_WIDTH)
        ) u_lane (
            .outcome(s1_data[g*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
            .shift  (shift_q),
            .result (lane_res[(ARRAY_SIZE-1-g)*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state        <= ST_IDLE;
            matrix_index <= '0;
            shift_q      <= '0;
            base_q       <= '0;
            s1_valid     <= 1'b0;
            s1_idx       <= '0;
            s1_data      <= '0;
            sram_wen     <= 1'b0;
            sram_waddr   <= '0;
            sram_wdata   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done     <= 1'b0;
            s1_valid <= (state == ST_DRAIN);
            s1_idx   <= matrix_index;
            s1_data  <= mul_outcome;
            sram_wen <= s1_valid;
            if (s1_valid) begin
                sram_waddr <= base_q + ADDR_WIDTH'(s1_idx);
                sram_wdata <= lane_res;
            end
            case (state)
                ST_IDLE: begin
                    // The done cycle is still part of the previous drain.
                    if (drain_start && !done) begin
                        state        <= ST_DRAIN;
                        busy         <= 1'b1;
                        matrix_index <= '0;
                        shift_q      <= (shift_amt > 5'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : shift_amt;
                        base_q       <= base_addr;
                    end
                end
                ST_DRAIN: begin
                    if (matrix_index == 6'(ARRAY_SIZE-1)) begin
                        state        <= ST_FLUSH;
                        matrix_index <= '0;
                    end else begin
                        matrix_index <= matrix_index + 6'd1;
                    end
                end
                ST_FLUSH: begin
                    if (!s1_valid) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_writeback.sv
// Randomized self-checking bench for systolic_writeback against a cycle-offset reference model.
module tb_systolic_writeback;

    localparam int AS = 8;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int OW = 2 * DW + 5;

    logic                    clk = 1'b0;
    logic                    srstn;
    logic                    drain_start;
    logic        [4:0]       shift_amt;
    logic        [AW-1:0]    base_addr;
    logic        [5:0]       matrix_index;
    logic signed [AS*OW-1:0] mul_outcome;
    logic                    sram_wen;
    logic        [AW-1:0]    sram_waddr;
    logic        [AS*DW-1:0] sram_wdata;
    logic                    busy;
    logic                    done;

    int errors = 0;
    int checks = 0;

    longint mat [AS][AS];

    always #5 clk = ~clk;

    systolic_writeback #(
        .ARRAY_SIZE(AS),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .srstn       (srstn),
        .drain_start (drain_start),
        .shift_amt   (shift_amt),
        .base_addr   (base_addr),
        .matrix_index(matrix_index),
        .mul_outcome (mul_outcome),
        .sram_wen    (sram_wen),
        .sram_waddr  (sram_waddr),
        .sram_wdata  (sram_wdata),
        .busy        (busy),
        .done        (done)
    );

    // Array model: the selected row of accumulators, combinationally.
    always_comb begin
        int mi;
        mul_outcome = '0;
        mi = int'(matrix_index);
        if (mi < AS)
            for (int i = 0; i < AS; i++)
                mul_outcome[i*OW +: OW] = OW'(mat[mi][i]);
    end

    function automatic logic [DW-1:0] exp_lane(input longint v, input int sh);
        int     s;
        longint r;
        logic   [DW-1:0] o;
        s = (sh > 20) ? 20 : sh;
        r = (s > 0) ? ((v + (longint'(1) << (s - 1))) >>> s) : v;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`ifdef SYSTOLIC_WB_RELU_EN
        if (r < 0) r = 0;
`endif
        o = r[DW-1:0];
        return o;
    endfunction

    function automatic logic [AS*DW-1:0] exp_vec(input int k, input int sh);
        logic [AS*DW-1:0] v;
        v = '0;
        for (int i = 0; i < AS; i++)
            v[(AS-1-i)*DW +: DW] = exp_lane(mat[k][i], sh);
        return v;
    endfunction

    function automatic longint rand_val();
        case ($urandom_range(0, 2))
            0:       return longint'($urandom_range(0, 600)) - 300;
            1:       return longint'($urandom_range(0, 40000)) - 20000;
            default: return longint'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
        endcase
    endfunction

    task automatic fill_random();
        for (int k = 0; k < AS; k++)
            for (int i = 0; i < AS; i++)
                mat[k][i] = rand_val();
    endtask

    // Offset j = cycles since drain_start was sampled; inputs are scrambled after the
    // start to show the captured shift/base are held.
    task automatic run_drain(input string tag, input int sh, input int base, input int inject_at);
        @(negedge clk);
        drain_start = 1'b1;
        shift_amt   = 5'(sh);
        base_addr   = AW'(base);
        for (int j = 1; j <= AS + 8; j++) begin
            int exp_mi;
            logic exp_busy, exp_done, exp_wen;
            logic [AW-1:0] exp_addr;
            logic [AS*DW-1:0] exp_data;
            @(negedge clk);
            drain_start = (j == inject_at);
            shift_amt   = 5'($urandom_range(0, 31));
            base_addr   = AW'($urandom);
            exp_mi   = (j >= 1 && j <= AS) ? j - 1 : 0;
            exp_busy = (j >= 1 && j <= AS + 2);
            exp_done = (j == AS + 3);
            exp_wen  = (j >= 3 && j <= AS + 2);
            checks++;
            if (matrix_index !== 6'(exp_mi)) begin
                errors++;
                $display("FAIL %s matrix_index j=%0d got %0d exp %0d", tag, j, matrix_index, exp_mi);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy j=%0d got %b exp %b", tag, j, busy, exp_busy);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL %s done j=%0d got %b exp %b", tag, j, done, exp_done);
            end
            checks++;
            if (sram_wen !== exp_wen) begin
                errors++;
                $display("FAIL %s sram_wen j=%0d got %b exp %b", tag, j, sram_wen, exp_wen);
            end
            if (exp_wen && sram_wen === 1'b1) begin
                exp_addr = AW'((base + j - 3) % (1 << AW));
                exp_data = exp_vec(j - 3, sh);
                checks++;
                if (sram_waddr !== exp_addr) begin
                    errors++;
                    $display("FAIL %s sram_waddr k=%0d got %h exp %h", tag, j - 3, sram_waddr, exp_addr);
                end
                checks++;
                if (sram_wdata !== exp_data) begin
                    errors++;
                    $display("FAIL %s sram_wdata k=%0d got %h exp %h", tag, j - 3, sram_wdata, exp_data);
                end
            end
        end
        drain_start = 1'b0;
    endtask

    task automatic test_reset();
        srstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sram_wen, busy, done, matrix_index, sram_waddr, sram_wdata} !== '0) begin
            errors++;
            $display("FAIL reset outputs got wen=%b busy=%b done=%b mi=%0d addr=%h data=%h exp all 0",
                     sram_wen, busy, done, matrix_index, sram_waddr, sram_wdata);
        end
        srstn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sram_wen !== 1'b0) begin
            errors++;
            $display("FAIL reset idle got busy=%b wen=%b exp 0 0", busy, sram_wen);
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < AS; k++)
            for (int i = 0; i < AS; i++)
                mat[k][i] = 5;
        run_drain("basic", 0, 'h010, 0);
    endtask

    task automatic test_rounding();
        fill_random();
        for (int k = 0; k < AS; k++) begin
            mat[k][0] = 24;
            mat[k][1] = 23;
            mat[k][2] = -24;
            mat[k][3] = 8;
            mat[k][4] = -8;
            mat[k][5] = -9;
        end
        run_drain("rounding", 4, 'h100, 0);
    endtask

    task automatic test_saturation();
        fill_random();
        for (int k = 0; k < AS; k++) begin
            mat[k][0] = 1000;
            mat[k][1] = -1000;
            mat[k][2] = 127;
            mat[k][3] = -128;
            mat[k][4] = (1 << 20) - 1;
            mat[k][5] = -(1 << 20);
        end
        run_drain("saturation", 0, 'h200, 0);
        run_drain("sat_shift1", 1, 'h210, 0);
    endtask

    task automatic test_wrap();
        fill_random();
        run_drain("wrap", 'h3FE, 'h3FE, 0);
    endtask

    task automatic test_shift_clamp();
        fill_random();
        for (int k = 0; k < AS; k++) mat[k][0] = (1 << 20) - 1;
        run_drain("shift25", 25, 'h050, 0);
        fill_random();
        run_drain("shift31", 31, 'h060, 0);
        fill_random();
        run_drain("shift20", 20, 'h070, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            fill_random();
            run_drain("random", int'($urandom_range(0, 31)), int'($urandom_range(0, (1 << AW) - 1)), 0);
        end
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_drain("restart_mid", 3, 'h0A0, 4);
        fill_random();
        run_drain("restart_done", 6, 'h0C0, AS + 3);
        fill_random();
        run_drain("after_done", 2, 'h0E0, 0);
    endtask

    task automatic test_reset_mid_drain();
        fill_random();
        @(negedge clk);
        drain_start = 1'b1;
        shift_amt   = 5'd2;
        base_addr   = AW'('h300);
        for (int j = 1; j <= AS + 6; j++) begin
            @(negedge clk);
            drain_start = 1'b0;
            if (j >= 4) begin
                checks++;
                if (sram_wen !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || matrix_index !== 6'd0) begin
                    errors++;
                    $display("FAIL reset_mid j=%0d got wen=%b done=%b busy=%b mi=%0d exp 0 0 0 0",
                             j, sram_wen, done, busy, matrix_index);
                end
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_mid busy j=%0d got %b exp 1", j, busy);
                end
            end
            srstn = (j != 3);
        end
        srstn = 1'b1;
    endtask

    initial begin
        srstn       = 1'b0;
        drain_start = 1'b0;
        shift_amt   = '0;
        base_addr   = '0;
        fill_random();
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_wrap();
        test_shift_clamp();
        test_random();
        test_back_to_back();
        test_reset_mid_drain();
        fill_random();
        run_drain("post_reset", 5, 'h3F0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
